// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Holds FSM states, byte-enable width and the lane-select helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam int BE_W = 4;

  function automatic logic [BE_W-1:0] lane_sel(
    input logic [1:0] ofs
  );
    return 4'b0001 << ofs;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and memory.
// master: controller drives req/we/be/addr/wdata; slave: memory.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [BE_W-1:0] dmem_be;
  logic [31:0]     dmem_addr;
  logic [31:0]     dmem_wdata;
  logic            dmem_ack;
  logic [31:0]     dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_be,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_be,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: byte enables, store-data replication, load extract.
// Ports: is_byte, ofs (addr[1:0]), wdata, rdata_in -> be, wdata_out, load_data.
module mem_byte_lane
  import mem_ctrl_pkg::*;
(
  input  logic            is_byte,
  input  logic [1:0]      ofs,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rdata_in,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_out,
  output logic [31:0]     load_data
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte  = rdata_in[{ofs, 3'b000} +: 8];
    be        = '1;
    wdata_out = wdata;
    load_data = rdata_in;
    if (is_byte) begin
      be        = lane_sel(ofs);
      wdata_out = {4{wdata[7:0]}};
      load_data = {24'h0, sel_byte};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: stalls the pipeline around one access.
// Ports: clk, rst_n, access inputs, hold, dmem bus (master), rdata, errors.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc_valid,
  input  logic               mem_write,
  input  logic               mem_read,
  input  logic               is_byte,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               hold,
  mem_access_ctrl_if.master  dmem,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic               err_misalign,
  output logic               err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        byte_q;
  logic        wr_q;

  logic        access;
  logic        aligned;
  logic        cnt_hit;
  logic        lat;
  logic        cap;
  logic        mis_set;
  logic        to_set;

  logic [BE_W-1:0] lane_be;
  logic [31:0]     lane_wd;
  logic [31:0]     lane_ld;

  mem_byte_lane u_lane (
    .is_byte   (byte_q),
    .ofs       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata_in  (dmem.dmem_rdata),
    .be        (lane_be),
    .wdata_out (lane_wd),
    .load_data (lane_ld)
  );

  assign access  = acc_valid & (mem_write | mem_read);
  assign aligned = is_byte | (addr[1:0] == 2'b00);
  // Counter holds BUSY cycles already spent; this is the last allowed one.
  assign cnt_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d          = state;
    hold             = 1'b0;
    dmem.dmem_req    = 1'b0;
    dmem.dmem_we     = 1'b0;
    dmem.dmem_be     = '0;
    dmem.dmem_addr   = '0;
    dmem.dmem_wdata  = '0;
    rdata_valid      = 1'b0;
    lat              = 1'b0;
    cap              = 1'b0;
    mis_set          = 1'b0;
    to_set           = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            hold    = 1'b1;
            lat     = 1'b1;
            state_d = S_BUSY;
          end else begin
            mis_set = 1'b1;
          end
        end
      end
      S_BUSY: begin
        hold            = 1'b1;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = wr_q;
        dmem.dmem_be    = lane_be;
        dmem.dmem_addr  = {addr_q[31:2], 2'b00};
        dmem.dmem_wdata = lane_wd;
        // A late ack in the expiring cycle still completes normally.
        if (dmem.dmem_ack) begin
          cap     = 1'b1;
          state_d = S_DONE;
        end else if (cnt_hit) begin
          to_set  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rdata_valid = ~wr_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else if (lat) begin
      cnt     <= '0;
      addr_q  <= addr;
      wdata_q <= wdata;
      byte_q  <= is_byte;
      wr_q    <= mem_write;
    end else if (state == S_BUSY) begin
      cnt     <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (cap) begin
        rdata <= lane_ld;
      end else if (to_set) begin
        rdata <= '0;
      end
      if (mis_set) begin
        err_misalign <= 1'b1;
      end
      if (to_set) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl (TIMEOUT=4).
// Stimulus pushes expected bus/load data; a negedge monitor compares.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        acc_valid;
  logic        mem_write;
  logic        mem_read;
  logic        is_byte;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hold;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err_misalign;
  logic        err_timeout;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_valid    (acc_valid),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .is_byte      (is_byte),
    .addr         (addr),
    .wdata        (wdata),
    .hold         (hold),
    .dmem         (bus),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        req_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dmem_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected none",
                   bus.dmem_addr);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          check("req_we", 32'(bus.dmem_we), 32'(e.we));
          check("req_be", 32'(bus.dmem_be), 32'(e.be));
          check("req_addr", bus.dmem_addr, e.addr);
          check("req_hold", 32'(hold), 32'd1);
          if (e.chk_wd) check("req_wdata", bus.dmem_wdata, e.wdata);
        end
      end
      if (rdata_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdata_valid: got %h expected none",
                   rdata);
        end else begin
          check("load_rdata", rdata, rd_q.pop_front());
        end
      end
    end
    req_prev = bus.dmem_req && rst_n;
  end

  // k: cycle (relative to issue) at which ack is pulsed; 0 = never.
  task automatic access(input logic w, input logic r, input logic b,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int k, input logic [31:0] mrd,
                        output int stall);
    int c;
    stall = 0;
    c = 0;
    @(posedge clk);
    #1;
    acc_valid = 1'b1;
    mem_write = w;
    mem_read  = r;
    is_byte   = b;
    addr      = a;
    wdata     = wd;
    bus.dmem_rdata = mrd;
    forever begin
      bus.dmem_ack = (k > 0) && (c == k);
      @(negedge clk);
      if (!hold) break;
      stall++;
      @(posedge clk);
      #1;
      c++;
      if (c > 50) begin
        checks++;
        errors++;
        $display("FAIL hold_bound: got %0d cycles expected <= 50", c);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_valid    = 1'b0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    rst_n = 1'b0;
    acc_valid = 1'b0;
    mem_write = 1'b0;
    mem_read = 1'b0;
    is_byte = 1'b0;
    addr = '0;
    wdata = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;

    @(negedge clk);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_we", 32'(bus.dmem_we), 32'd0);
    check("rst_be", 32'(bus.dmem_be), 32'd0);
    check("rst_addr", bus.dmem_addr, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", 32'(rdata_valid), 32'd0);
    check("rst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(bus.dmem_req), 32'd0);

    bus_q.push_back('{1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1});
    access(1, 0, 0, 32'h100, 32'hDEADBEEF, 3, 32'h0, st);
    check("wstore_stall", 32'(st), 32'd4);

    bus_q.push_back('{1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1'b1});
    access(1, 0, 1, 32'h103, 32'h000000A5, 1, 32'h0, st);
    check("bstore_stall", 32'(st), 32'd2);

    bus_q.push_back('{1'b0, 4'b0100, 32'h100, 32'h0, 1'b0});
    rd_q.push_back(32'h00000022);
    access(0, 1, 1, 32'h102, 32'h0, 1, 32'h11223344, st);
    check("bload_stall", 32'(st), 32'd2);

    bus_q.push_back('{1'b0, 4'hF, 32'h200, 32'h0, 1'b0});
    rd_q.push_back(32'hCAFEF00D);
    access(0, 1, 0, 32'h200, 32'h0, 2, 32'hCAFEF00D, st);
    check("wload_stall", 32'(st), 32'd3);
    check("mis_clear", 32'(err_misalign), 32'd0);

    access(0, 1, 0, 32'h101, 32'h0, 1, 32'h0, st);
    check("mis_stall", 32'(st), 32'd0);
    @(negedge clk);
    check("mis_flag", 32'(err_misalign), 32'd1);

    bus_q.push_back('{1'b0, 4'b1000, 32'h200, 32'h0, 1'b0});
    rd_q.push_back(32'h00000088);
    access(0, 1, 1, 32'h203, 32'h0, 4, 32'h8899AABB, st);
    check("ackwin_stall", 32'(st), 32'd5);
    check("ackwin_noto", 32'(err_timeout), 32'd0);

    bus_q.push_back('{1'b0, 4'hF, 32'h304, 32'h0, 1'b0});
    rd_q.push_back(32'h0);
    access(0, 1, 0, 32'h304, 32'h0, 0, 32'hFFFFFFFF, st);
    check("to_stall", 32'(st), 32'd5);
    check("to_flag", 32'(err_timeout), 32'd1);
    check("mis_sticky", 32'(err_misalign), 32'd1);

    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    check("idle_ack_hold", 32'(hold), 32'd0);
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;

    bus_q.push_back('{1'b1, 4'hF, 32'h400, 32'h12345678, 1'b1});
    @(posedge clk);
    #1;
    acc_valid = 1'b1;
    mem_write = 1'b1;
    is_byte = 1'b0;
    addr = 32'h400;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("busy_hold", 32'(hold), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hold", 32'(hold), 32'd0);
    check("arst_req", 32'(bus.dmem_req), 32'd0);
    check("arst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0, 1'b0});
    rd_q.push_back(32'h0BADF00D);
    access(0, 1, 0, 32'h500, 32'h0, 1, 32'h0BADF00D, st);
    check("fresh_stall", 32'(st), 32'd2);

    repeat (2) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
